// File: rtl/bpd_pkg.sv
// Shared types and sizing for the branch-predictor update scheduler.
// Holds table geometry, the queued update entry layout and the scheduler FSM states.
package bpd_pkg;

  localparam int unsigned PhtLogSize = 12;
  localparam int unsigned LocHistW   = 10;
  localparam int unsigned GhrW       = 12;
  localparam int unsigned FifoDepth  = 4;
  localparam int unsigned FifoPtrW   = $clog2(FifoDepth);
  localparam int unsigned FifoCntW   = $clog2(FifoDepth + 1);
  localparam int unsigned StarveW    = 3;

  localparam logic [StarveW-1:0] StarveMax = '1;

  // 64 + 12 + 10 + 1 + 1 + 1 = 89 bits
  typedef struct packed {
    logic [63:0]         pc;
    logic [GhrW-1:0]     bhr;
    logic [LocHistW-1:0] lochist;
    logic                brdir;
    logic                ch_we;
    logic                ch_ud;
  } upd_entry_t;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StDrain
  } sched_state_e;

endpackage

// File: rtl/bpd_upd_fifo.sv
// In-order update FIFO; the head is always visible and a push is never bypassed to the head.
// Contents are not reset, only count and pointers.
module bpd_upd_fifo
  import bpd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  upd_entry_t push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output upd_entry_t head_o
);

  upd_entry_t            mem_q [FifoDepth];
  logic [FifoPtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FifoPtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FifoCntW-1:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FifoCntW'(FifoDepth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + FifoPtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + FifoPtrW'(1);
    if (do_push && !do_pop)      count_d = count_q + FifoCntW'(1);
    else if (!do_push && do_pop) count_d = count_q - FifoCntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bpd_upd_sched.sv
// Schedules retired branch updates into predictor tables around fetch reads,
// and sweeps all table entries to their init value after reset or a reinit request.
module bpd_upd_sched
  import bpd_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enq_valid_i,
  output logic                  enq_ready_o,
  input  logic [63:0]           enq_pc_i,
  input  logic [GhrW-1:0]       enq_bhr_i,
  input  logic [LocHistW-1:0]   enq_lochist_i,
  input  logic                  enq_brdir_i,
  input  logic                  enq_ch_we_i,
  input  logic                  enq_ch_ud_i,
  input  logic                  fetch_rd_i,
  input  logic                  reinit_i,
  output logic                  upd_valid_o,
  output logic [63:0]           upd_pc_o,
  output logic [GhrW-1:0]       upd_bhr_o,
  output logic [LocHistW-1:0]   upd_lochist_o,
  output logic                  upd_brdir_o,
  output logic                  upd_ch_we_o,
  output logic                  upd_ch_ud_o,
  output logic                  init_we_o,
  output logic [PhtLogSize-1:0] init_idx_o,
  output logic                  fetch_stall_o,
  output logic                  busy_o
);

  sched_state_e            state_q, state_d;
  logic [PhtLogSize-1:0]   idx_q, idx_d;
  logic [StarveW-1:0]      starve_q, starve_d;
  logic                    full, empty;
  upd_entry_t              enq_entry, head;

  assign enq_entry = '{pc: enq_pc_i, bhr: enq_bhr_i, lochist: enq_lochist_i,
                       brdir: enq_brdir_i, ch_we: enq_ch_we_i, ch_ud: enq_ch_ud_i};

  bpd_upd_fifo u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (enq_valid_i & enq_ready_o),
    .push_data_i (enq_entry),
    .pop_i       (upd_valid_o),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head)
  );

  assign upd_pc_o      = head.pc;
  assign upd_bhr_o     = head.bhr;
  assign upd_lochist_o = head.lochist;
  assign upd_brdir_o   = head.brdir;
  assign upd_ch_we_o   = head.ch_we;
  assign upd_ch_ud_o   = head.ch_ud;
  assign init_idx_o    = idx_q;
  assign busy_o        = (state_q != StRun);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StInit;
      idx_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StInit: begin
        idx_d = idx_q + PhtLogSize'(1);
        if (idx_q == '1) state_d = StRun;
      end
      StRun: begin
        if (reinit_i) state_d = StDrain;
      end
      StDrain: begin
        if (empty) begin
          state_d = StInit;
          idx_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase
    // Starvation only accrues while an entry waits behind a fetch read.
    if (empty || upd_valid_o)                   starve_d = '0;
    else if (fetch_rd_i && starve_q != StarveMax) starve_d = starve_q + StarveW'(1);
    else                                        starve_d = starve_q;
  end

  always_comb begin
    enq_ready_o   = 1'b0;
    upd_valid_o   = 1'b0;
    fetch_stall_o = 1'b0;
    init_we_o     = 1'b0;
    unique case (state_q)
      StInit: begin
        init_we_o     = 1'b1;
        fetch_stall_o = 1'b1;
      end
      StRun: begin
        enq_ready_o   = ~full;
        upd_valid_o   = ~empty & (~fetch_rd_i | full | (starve_q == StarveMax));
        fetch_stall_o = upd_valid_o & fetch_rd_i;
      end
      StDrain: begin
        upd_valid_o   = ~empty;
        fetch_stall_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bpd_upd_sched.md
BPD_UPD_SCHED -- requirements
Module: bpd_upd_sched

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have port `clock`, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port `reset`, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port `enq_valid_i`, input, 1 bit: retired conditional branch update offered.
REQ-005 SHALL have port `enq_ready_o`, output, 1 bit: update accepted when high with `enq_valid_i`.
REQ-006 SHALL have enqueue payload input ports:
- `enq_pc_i`, 64 bits: branch PC.
- `enq_bhr_i`, 12 bits: global history at prediction.
- `enq_lochist_i`, 10 bits: local history at prediction.
- `enq_brdir_i`, 1 bit: resolved direction.
- `enq_ch_we_i`, 1 bit: choice update enable.
- `enq_ch_ud_i`, 1 bit: choice update direction.
REQ-007 SHALL have port `fetch_rd_i`, input, 1 bit: fetch stage reading predictor tables this cycle.
REQ-008 SHALL have port `reinit_i`, input, 1 bit: pulse requesting full table re-initialisation.
REQ-009 SHALL have port `upd_valid_o`, output, 1 bit: write FIFO head into predictor tables this cycle.
REQ-010 SHALL have update payload output ports `upd_pc_o` (64), `upd_bhr_o` (12), `upd_lochist_o` (10), `upd_brdir_o` (1), `upd_ch_we_o` (1) and `upd_ch_ud_o` (1), each the FIFO head field.
REQ-011 SHALL have port `init_we_o`, output, 1 bit: write the init value to all tables at `init_idx_o`.
REQ-012 SHALL have port `init_idx_o`, output, 12 bits: sweep index.
REQ-013 SHALL have port `fetch_stall_o`, output, 1 bit: fetch must hold; tables are not readable this cycle.
REQ-014 SHALL have port `busy_o`, output, 1 bit: state is not RUN.

Function
REQ-015 SHALL buffer updates in a 4-entry in-order FIFO of 89-bit entries, with no enqueue-to-output bypass, so the minimum enqueue-to-issue latency is 1 cycle.
REQ-016 SHALL drive `enq_ready_o` = (state==RUN) & !full; an enqueue while full is impossible by handshake and is never accepted.
REQ-017 SHALL implement FSM states INIT, RUN and DRAIN, with reset state INIT.
REQ-018 SHALL behave in INIT as follows:
- `init_we_o`=1 and `fetch_stall_o`=1.
- `init_idx_o` increments by 1 per cycle from 0.
- When `init_idx_o`==4095 the index wraps to 0 and the next state is RUN; the sweep totals 4096 cycles.
REQ-019 SHALL behave in RUN as follows:
- `upd_valid_o` = !empty & (!`fetch_rd_i` | full | starve==7).
- `fetch_stall_o` = `upd_valid_o` & `fetch_rd_i`.
REQ-020 SHALL maintain a 3-bit starve counter:
- Increments each cycle in which !empty & `fetch_rd_i` & !`upd_valid_o`.
- Clears on any issue or when the FIFO is empty.
- Saturates at 7.
REQ-021 SHALL, in RUN, transition to DRAIN on `reinit_i`; an enqueue accepted in that same cycle is still stored.
REQ-022 SHALL behave in DRAIN as follows:
- `enq_ready_o`=0.
- `upd_valid_o` = !empty, regardless of `fetch_rd_i`.
- `fetch_stall_o` = 1.
- When empty, the next state is INIT with index 0.
REQ-023 SHALL ignore `reinit_i` in INIT and in DRAIN.
REQ-024 SHALL pop the FIFO on every cycle with `upd_valid_o`=1; a simultaneous push and pop leaves the count unchanged; pointers are 2-bit and wrap modulo 4.
REQ-025 SHALL drive the payload outputs from the head entry at all times; their values are don't-care when `upd_valid_o`=0.

Reset
REQ-026 SHALL, when `reset` is sampled high, set state=INIT, `init_idx_o`=0, FIFO count/pointers=0 and starve=0, discarding FIFO contents.
REQ-027 SHALL, in the first cycle after reset, drive `upd_valid_o`=0, `enq_ready_o`=0, `init_we_o`=1, `init_idx_o`=0, `fetch_stall_o`=1 and `busy_o`=1.
REQ-028 SHALL, on reset asserted mid-sweep or mid-drain, restart the sweep at index 0.

Structure
REQ-029 SHALL place in shared package `bpd_pkg`:
- The constants for PHT log size (12), local history width (10), GHR width (12) and FIFO depth (4).
- The update-entry struct typedef.
- The FSM state enum.
REQ-030 SHALL implement the FIFO as sub-module `bpd_upd_fifo`, with push/pop/full/empty/head ports; the FSM, arbitration and starve counter reside in `bpd_upd_sched`.

Verification
REQ-031 SHALL verify reset then idle: `init_we_o`=1 for exactly 4096 cycles with indices 0..4095, then `busy_o`=0, `enq_ready_o`=1 and `fetch_stall_o`=0.
REQ-032 SHALL verify a single enqueue with PC=0x1000, brdir=1 and `fetch_rd_i`=0: the next cycle has `upd_valid_o`=1 with `upd_pc_o`=0x1000 and `upd_brdir_o`=1, and the cycle after has `upd_valid_o`=0.
REQ-033 SHALL verify 4 back-to-back enqueues with `fetch_rd_i`=1: `enq_ready_o` drops after the 4th; then an issue occurs with `fetch_stall_o`=1; entries drain in order.
REQ-034 SHALL verify starvation: 1 entry with `fetch_rd_i` held at 1 produces `upd_valid_o`=1 on the 8th cycle after enqueue, with `fetch_stall_o`=1.
REQ-035 SHALL verify reinit with 3 queued entries: DRAIN issues 3 updates on consecutive cycles, then INIT restarts at index 0; `reinit_i` pulsed during INIT has no effect.
REQ-036 SHALL verify reset asserted at sweep index 2000: the next sweep starts at 0 and the FIFO is empty.
